// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared widths, constants and the raw-sum record type used by
//                the post-add normaliser of the FFT floating-point datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

  // Raw mantissa: bit 27 carry, bit 26 hidden, bits 2:0 guard/round/sticky
  localparam int SIZE_MANT  = 28;
  // Biased exponent width
  localparam int SIZE_EXP   = 8;
  // Shift-amount width, covers 0..SIZE_MANT-1
  localparam int SIZE_SHIFT = 5;

  // All-ones exponent marks overflow
  localparam logic [SIZE_EXP-1:0] EXP_MAX = '1;

  // One raw adder result travelling through the first stage
  typedef struct packed {
    logic                 sign;
    logic [SIZE_EXP-1:0]  exp;
    logic [SIZE_MANT-1:0] mant;
  } fp_raw_t;

endpackage
`default_nettype wire

// File: rtl/fpu_norm_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_norm_pipe_if
//  Description : Handshake and data bundle of the normaliser. Signal names are
//                given from the normaliser's point of view (i_* flows into the
//                block, o_* flows out of it).
//                  upstream   : i_valid, o_ready, i_sign, i_exp, i_mant
//                  downstream : o_valid, i_ready, o_sign, o_exp, o_mant,
//                               o_overflow, o_underflow
//                slave  - modport taken by the normaliser
//                master - modport taken by the surrounding datapath
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpu_norm_pipe_if;
  import fpu_pkg::*;

  logic                 i_valid;
  logic                 o_ready;
  logic                 i_sign;
  logic [SIZE_EXP-1:0]  i_exp;
  logic [SIZE_MANT-1:0] i_mant;

  logic                 o_valid;
  logic                 i_ready;
  logic                 o_sign;
  logic [SIZE_EXP-1:0]  o_exp;
  logic [SIZE_MANT-2:0] o_mant;
  logic                 o_overflow;
  logic                 o_underflow;

  modport slave (
    input  i_valid, i_sign, i_exp, i_mant, i_ready,
    output o_ready, o_valid, o_sign, o_exp, o_mant, o_overflow, o_underflow
  );

  modport master (
    output i_valid, i_sign, i_exp, i_mant, i_ready,
    input  o_ready, o_valid, o_sign, o_exp, o_mant, o_overflow, o_underflow
  );

endinterface
`default_nettype wire

// File: rtl/lzc.sv
`default_nettype none
// ============================================================================
//  Module      : lzc
//  Description : Parameterised leading-zero counter. Returns the number of
//                zero bits above the most significant set bit; an all-zero
//                input returns SIZE_DATA.
//  Ports       : i_data  [SIZE_DATA-1:0]  value to scan
//                o_count [SIZE_COUNT-1:0] leading-zero count
//  Revision    : 1.0 - initial release
// ============================================================================
module lzc #(
  parameter int SIZE_DATA  = 27,
  parameter int SIZE_COUNT = 5
) (
  input  logic [SIZE_DATA-1:0]  i_data,
  output logic [SIZE_COUNT-1:0] o_count
);

  // Scan from the LSB upward so the highest set bit is the last to write.
  always_comb begin
    o_count = SIZE_COUNT'(SIZE_DATA);
    for (int i = 0; i < SIZE_DATA; i++) begin
      if (i_data[i]) begin
        o_count = SIZE_COUNT'(SIZE_DATA - 1 - i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/shf_left.sv
`default_nettype none
// ============================================================================
//  Module      : shf_left
//  Description : Logarithmic left barrel shifter, zero fill.
//  Ports       : i_data  [SIZE_DATA-1:0]  value to shift
//                i_shift [SIZE_SHIFT-1:0] shift amount
//                o_data  [SIZE_DATA-1:0]  shifted value
//  Revision    : 1.0 - initial release
// ============================================================================
module shf_left #(
  parameter int SIZE_DATA  = 27,
  parameter int SIZE_SHIFT = 5
) (
  input  logic [SIZE_DATA-1:0]  i_data,
  input  logic [SIZE_SHIFT-1:0] i_shift,
  output logic [SIZE_DATA-1:0]  o_data
);

  logic [SIZE_DATA-1:0] w_stage [0:SIZE_SHIFT];

  assign w_stage[0] = i_data;

  // Stage s shifts by 2**s when bit s of the amount is set.
  for (genvar s = 0; s < SIZE_SHIFT; s++) begin : g_stage
    assign w_stage[s+1] = i_shift[s] ? (w_stage[s] << (1 << s)) : w_stage[s];
  end

  assign o_data = w_stage[SIZE_SHIFT];

endmodule
`default_nettype wire

// File: rtl/fpu_norm_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_norm_pipe
//  Description : Two-stage post-add normaliser between the mantissa adder and
//                the rounder. S1 registers the raw sum with its carry bit and
//                leading-zero count; S2 applies carry right-shift, zero,
//                flush-to-zero underflow or left normalisation, and registers
//                the result. Valid/ready handshake, 2-cycle latency, one
//                result per cycle.
//  Ports       : i_clk  clock
//                i_rst  synchronous active-high reset
//                bus    handshake/data bundle (slave side)
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_norm_pipe
  import fpu_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  fpu_norm_pipe_if.slave bus
);

  localparam int c_mant_out = SIZE_MANT - 1;
  localparam int c_exp_ext  = SIZE_EXP + 1;

  // --------------------------------------------------------------------------
  // Handshake: a stage advances when it is empty or the stage after it moves.
  // --------------------------------------------------------------------------
  logic r_s1_valid;
  logic r_valid;
  logic w_s2_en;
  logic w_s1_en;

  assign w_s2_en     = !r_valid || bus.i_ready;
  assign w_s1_en     = !r_s1_valid || w_s2_en;
  assign bus.o_ready = w_s1_en;

  // --------------------------------------------------------------------------
  // Stage 1: capture raw sum, carry and leading-zero count of mant[26:0]
  // --------------------------------------------------------------------------
  fp_raw_t               r_s1;
  logic                  r_s1_carry;
  logic [SIZE_SHIFT-1:0] r_s1_lzc;
  logic [SIZE_SHIFT-1:0] w_lzc;

  lzc #(
    .SIZE_DATA  (c_mant_out),
    .SIZE_COUNT (SIZE_SHIFT)
  ) u_lzc (
    .i_data  (bus.i_mant[c_mant_out-1:0]),
    .o_count (w_lzc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
      r_s1_carry <= 1'b0;
      r_s1_lzc   <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= bus.i_valid;
      r_s1       <= '{sign: bus.i_sign, exp: bus.i_exp, mant: bus.i_mant};
      r_s1_carry <= bus.i_mant[SIZE_MANT-1];
      r_s1_lzc   <= w_lzc;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 datapath. Exponent maths is one bit wider so nothing wraps.
  // --------------------------------------------------------------------------
  logic [c_exp_ext-1:0]  w_exp_ext;
  logic [c_exp_ext-1:0]  w_exp_inc;
  logic [c_exp_ext-1:0]  w_exp_sub;
  logic [c_exp_ext-1:0]  w_lzc_ext;
  logic [c_mant_out-1:0] w_mant_rsh;
  logic [c_mant_out-1:0] w_mant_lsh;
  logic                  w_is_zero;
  logic                  w_ovf_hit;
  logic                  w_unf_hit;

  assign w_exp_ext = {1'b0, r_s1.exp};
  assign w_lzc_ext = {{(c_exp_ext-SIZE_SHIFT){1'b0}}, r_s1_lzc};
  assign w_exp_inc = w_exp_ext + c_exp_ext'(1);
  assign w_exp_sub = w_exp_ext - w_lzc_ext;

  // Right shift by one on carry-out; the two dropped bits fold into sticky.
  assign w_mant_rsh = {r_s1.mant[SIZE_MANT-1:2], r_s1.mant[1] | r_s1.mant[0]};

  // An input exponent already at all-ones would step past it; treat that as
  // overflow too rather than letting it alias back to a small exponent.
  assign w_ovf_hit  = (w_exp_inc >= {1'b0, EXP_MAX});
  assign w_is_zero  = (r_s1.mant == '0);
  // lzc >= exp  <=>  exp - lzc is negative (top bit set) or exactly zero.
  assign w_unf_hit  = w_exp_sub[c_exp_ext-1] || (w_exp_sub == '0);

  shf_left #(
    .SIZE_DATA  (c_mant_out),
    .SIZE_SHIFT (SIZE_SHIFT)
  ) u_shf_left (
    .i_data  (r_s1.mant[c_mant_out-1:0]),
    .i_shift (r_s1_lzc),
    .o_data  (w_mant_lsh)
  );

  logic [SIZE_EXP-1:0]   w_nxt_exp;
  logic [c_mant_out-1:0] w_nxt_mant;
  logic                  w_nxt_ovf;
  logic                  w_nxt_unf;

  always_comb begin
    w_nxt_exp  = '0;
    w_nxt_mant = '0;
    w_nxt_ovf  = 1'b0;
    w_nxt_unf  = 1'b0;
    if (r_s1_carry) begin
      if (w_ovf_hit) begin
        w_nxt_exp = EXP_MAX;
        w_nxt_ovf = 1'b1;
      end else begin
        w_nxt_exp  = w_exp_inc[SIZE_EXP-1:0];
        w_nxt_mant = w_mant_rsh;
      end
    end else if (w_is_zero) begin
      w_nxt_exp  = '0;
      w_nxt_mant = '0;
    end else if (w_unf_hit) begin
      w_nxt_unf = 1'b1;
    end else begin
      w_nxt_exp  = w_exp_sub[SIZE_EXP-1:0];
      w_nxt_mant = w_mant_lsh;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 output register. Data only reloads when a real item arrives, so
  // a bubble leaves the last result parked on the outputs.
  // --------------------------------------------------------------------------
  logic                  r_sign;
  logic [SIZE_EXP-1:0]   r_exp;
  logic [c_mant_out-1:0] r_mant;
  logic                  r_ovf;
  logic                  r_unf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_mant  <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (w_s2_en) begin
      r_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sign <= r_s1.sign;
        r_exp  <= w_nxt_exp;
        r_mant <= w_nxt_mant;
        r_ovf  <= w_nxt_ovf;
        r_unf  <= w_nxt_unf;
      end
    end
  end

  assign bus.o_valid     = r_valid;
  assign bus.o_sign      = r_sign;
  assign bus.o_exp       = r_exp;
  assign bus.o_mant      = r_mant;
  assign bus.o_overflow  = r_ovf;
  assign bus.o_underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_fpu_norm_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_norm_pipe
//  Description : Self-checking bench for fpu_norm_pipe: directed vectors,
//                backpressure, mid-stream reset and randomized traffic
//                scored against a behavioural normalisation model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_norm_pipe;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [26:0] mant;
    logic        ovf;
    logic        unf;
  } res_t;

  logic i_clk;
  logic i_rst;
  int   n_cmp;
  int   n_fail;
  int   n_out;
  res_t q[$];

  fpu_norm_pipe_if bus();

  fpu_norm_pipe dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: normalise from the arithmetic rules directly.
  function automatic res_t model(input logic s, input logic [7:0] e, input logic [27:0] m);
    res_t        r;
    int          ev;
    int          n;
    logic [26:0] f;
    r      = '0;
    r.sign = s;
    ev     = int'(e);
    if (m[27]) begin
      ev = ev + 1;
      if (ev >= 255) begin
        r.exp = 8'hFF;
        r.ovf = 1'b1;
      end else begin
        r.exp  = 8'(ev);
        r.mant = {m[27:2], m[1] | m[0]};
      end
    end else if (m != 28'h0) begin
      f = m[26:0];
      n = 0;
      while (!f[26]) begin
        f = f << 1;
        n++;
      end
      if (n >= ev) r.unf = 1'b1;
      else begin
        r.exp  = 8'(ev - n);
        r.mant = f;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic res_t out_now();
    return '{sign: bus.o_sign, exp: bus.o_exp, mant: bus.o_mant,
             ovf: bus.o_overflow, unf: bus.o_underflow};
  endfunction

  // Scoreboard: transfers are decided by signals stable at the falling edge.
  always @(negedge i_clk) begin
    if (i_rst) begin
      q.delete();
    end else begin
      if (bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 64'(bus.o_valid), 64'(0));
        end else begin
          chk("stream_result", 64'(out_now()), 64'(q[0]));
          void'(q.pop_front());
          n_out++;
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        q.push_back(model(bus.i_sign, bus.i_exp, bus.i_mant));
      end
    end
  end

  // Single transaction into an empty pipe, checked against literal values.
  task automatic single(input string tag, input logic s, input logic [7:0] e,
                        input logic [27:0] m, input res_t want);
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_sign  = s;
    bus.i_exp   = e;
    bus.i_mant  = m;
    @(posedge i_clk); #1;
    bus.i_valid = 1'b0;
    chk({tag, "_early"}, 64'(bus.o_valid), 64'(0));
    @(posedge i_clk); #1;
    chk({tag, "_valid"}, 64'(bus.o_valid), 64'(1));
    chk(tag, 64'(out_now()), 64'(want));
    @(posedge i_clk); #1;
  endtask

  initial begin
    int   idx;
    int   n_sent;
    int   out0;
    logic acc;
    logic pending;

    n_cmp  = 0;
    n_fail = 0;
    n_out  = 0;
    i_rst       = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_sign  = 1'b0;
    bus.i_exp   = '0;
    bus.i_mant  = '0;

    // ---- reset state ----
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", 64'(bus.o_valid), 64'(0));
    chk("rst_outputs", 64'(out_now()), 64'(0));
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("rst_ready", 64'(bus.o_ready), 64'(1));

    // ---- directed vectors ----
    single("normal",   1'b0, 8'd100, 28'h0400000, '{1'b0, 8'd96,  27'h4000000, 1'b0, 1'b0});
    single("carry",    1'b1, 8'd100, 28'h8000001, '{1'b1, 8'd101, 27'h4000001, 1'b0, 1'b0});
    single("overflow", 1'b0, 8'd254, 28'h8000000, '{1'b0, 8'd255, 27'h0,       1'b1, 1'b0});
    single("underflow",1'b1, 8'd3,   28'h0400000, '{1'b1, 8'd0,   27'h0,       1'b0, 1'b1});
    single("zero",     1'b1, 8'd50,  28'h0,       '{1'b1, 8'd0,   27'h0,       1'b0, 1'b0});
    single("hidden_set",1'b0,8'd1,   28'h4000005, '{1'b0, 8'd1,   27'h4000005, 1'b0, 1'b0});
    single("lzc_eq_exp",1'b0,8'd26,  28'h0000001, '{1'b0, 8'd0,   27'h0,       1'b0, 1'b1});
    single("lzc_max_ok",1'b0,8'd27,  28'h0000001, '{1'b0, 8'd1,   27'h4000000, 1'b0, 1'b0});

    // ---- backpressure: 4 back-to-back, downstream stalls on cycles 3..5 ----
    out0 = n_out;
    idx  = 0;
    acc  = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (acc) idx++;
      bus.i_ready = !(k >= 3 && k <= 5);
      if (idx < 4) begin
        bus.i_valid = 1'b1;
        bus.i_sign  = idx[0];
        bus.i_exp   = 8'(120 + idx);
        bus.i_mant  = 28'h0010000 << idx;
      end else begin
        bus.i_valid = 1'b0;
      end
      #1;
      if (k == 3) chk("bp_ready_low", 64'(bus.o_ready), 64'(0));
      if (k == 6) chk("bp_ready_back", 64'(bus.o_ready), 64'(1));
      acc = bus.i_valid && bus.o_ready;
      @(posedge i_clk); #1;
    end
    chk("bp_count", 64'(n_out - out0), 64'(4));

    // ---- reset with both stages full ----
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_sign  = 1'b1;
    bus.i_exp   = 8'd77;
    bus.i_mant  = 28'h0800000;
    @(posedge i_clk); #1;
    bus.i_mant  = 28'h1000000;
    @(posedge i_clk); #1;
    bus.i_valid = 1'b0;
    chk("mid_full", 64'({bus.o_valid, bus.o_ready}), 64'(2'b10));
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("mid_rst_valid", 64'(bus.o_valid), 64'(0));
    chk("mid_rst_outputs", 64'(out_now()), 64'(0));
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("mid_rst_ready", 64'(bus.o_ready), 64'(1));
    bus.i_ready = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    chk("mid_rst_discard", 64'(bus.o_valid), 64'(0));

    // ---- randomized traffic with random stalls ----
    out0    = n_out;
    n_sent  = 0;
    pending = 1'b0;
    for (int c = 0; c < 3000 && n_sent < 200; c++) begin
      bus.i_ready = ($urandom_range(0, 3) != 0);
      if (!pending && $urandom_range(0, 3) != 0) begin
        bus.i_sign = 1'($urandom);
        bus.i_exp  = 8'($urandom_range(0, 254));
        bus.i_mant = 28'($urandom) >> $urandom_range(0, 28);
        pending    = 1'b1;
      end
      bus.i_valid = pending;
      #1;
      if (pending && bus.o_ready) begin
        pending = 1'b0;
        n_sent++;
      end
      @(posedge i_clk); #1;
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    for (int t = 0; t < 20 && q.size() != 0; t++) begin
      @(posedge i_clk); #1;
    end
    chk("rand_sent", 64'(n_sent), 64'(200));
    chk("rand_drain", 64'(q.size()), 64'(0));
    chk("rand_count", 64'(n_out - out0), 64'(n_sent));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
